// File: rtl/mvm_uart_pkg.sv
// Shared constants for the UART matrix-vector multiplier.
// The derived constants below are evaluated at the default parameter values.
package mvm_uart_pkg;

  localparam int unsigned DefBitsPerWord = 8;
  localparam int unsigned DefR           = 8;
  localparam int unsigned DefC           = 8;
  localparam int unsigned DefWX          = 8;
  localparam int unsigned DefWK          = 8;
  localparam int unsigned DefWYOut       = 32;

  // Exact width of one dot product of C signed W_X x W_K products.
  function automatic int unsigned calc_w_y(input int unsigned w_x, input int unsigned w_k,
                                           input int unsigned c);
    return w_x + w_k + $clog2(c);
  endfunction

  localparam int unsigned W_Y        = calc_w_y(DefWX, DefWK, DefC);
  localparam int unsigned W_BUS_KX   = DefR * DefC * DefWK + DefC * DefWX;
  localparam int unsigned W_BUS_Y    = DefR * DefWYOut;
  localparam int unsigned N_WORDS_KX = W_BUS_KX / DefBitsPerWord;
  localparam int unsigned N_WORDS_Y  = W_BUS_Y / DefBitsPerWord;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxWaitIdle
  } rx_state_e;

  typedef enum logic {
    TxIdle,
    TxSend
  } tx_state_e;

endpackage

// File: rtl/mvm_uart_system_rx.sv
// UART word receiver: 2-flop synchroniser and bit-centre sampling FSM.
// Emits one word with a single-cycle valid pulse; framing errors drop the word.
module uart_rx_word
  import mvm_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 20833,
  parameter int unsigned BITS_PER_WORD    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rx_i,
  output logic [BITS_PER_WORD-1:0] word_o,
  output logic                     valid_o
);

  localparam int unsigned CntW = $clog2(CLOCKS_PER_PULSE + 1);
  localparam int unsigned BitW = $clog2(BITS_PER_WORD + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLOCKS_PER_PULSE - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(BITS_PER_WORD - 1);

  logic [1:0]               sync_q;
  logic                     prev_q;
  logic                     rx_s;
  rx_state_e                state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [BitW-1:0]          bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] data_q, data_d;
  logic                     valid_q, valid_d;

  assign rx_s    = sync_q[1];
  assign word_o  = data_q;
  assign valid_o = valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (prev_q && !rx_s) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          bit_d   = '0;
          // Line back high at the start-bit centre means it was a glitch.
          state_d = rx_s ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxData: begin
        if (cnt_q == CntLast) begin
          cnt_d  = '0;
          data_d = {rx_s, data_q[BITS_PER_WORD-1:1]};
          if (bit_q == BitLast) state_d = RxStop;
          else                  bit_d   = bit_q + BitW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s) begin
            valid_d = 1'b1;
            state_d = RxIdle;
          end else begin
            state_d = RxWaitIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RxWaitIdle: begin
        if (rx_s) state_d = RxIdle;
      end
      default: state_d = RxIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/mvm_uart_system.sv
// UART-attached matrix-vector multiplier: assembles K and X from RX bytes,
// computes Y = K*X one row per cycle and streams the results out on TX.
module mvm_uart_system
  import mvm_uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_PULSE = 20833,
  parameter int unsigned BITS_PER_WORD    = 8,
  parameter int unsigned PACKET_SIZE_TX   = 13,
  parameter int unsigned R                = 8,
  parameter int unsigned C                = 8,
  parameter int unsigned W_X              = 8,
  parameter int unsigned W_K              = 8,
  parameter int unsigned W_Y_OUT          = 32
) (
  input  logic clk,
  input  logic rstn,
  input  logic rx,
  output logic tx
);

  localparam int unsigned WidthY     = calc_w_y(W_X, W_K, C);
  localparam int unsigned WidthBusKx = R * C * W_K + C * W_X;
  localparam int unsigned WidthBusY  = R * W_Y_OUT;
  localparam int unsigned NumWordsKx = WidthBusKx / BITS_PER_WORD;
  localparam int unsigned NumWordsY  = WidthBusY / BITS_PER_WORD;
  localparam int unsigned WordCntW   = $clog2(NumWordsKx + 1);
  localparam int unsigned RowW       = $clog2(R + 1);
  localparam int unsigned TxWordW    = $clog2(NumWordsY + 1);
  localparam int unsigned TxBitW     = $clog2(PACKET_SIZE_TX + 1);
  localparam int unsigned TxCntW     = $clog2(CLOCKS_PER_PULSE + 1);

  localparam logic [WordCntW-1:0] WordLast   = WordCntW'(NumWordsKx - 1);
  localparam logic [RowW-1:0]     RowLast    = RowW'(R - 1);
  localparam logic [TxWordW-1:0]  TxWordLast = TxWordW'(NumWordsY - 1);
  localparam logic [TxBitW-1:0]   TxBitLast  = TxBitW'(PACKET_SIZE_TX - 1);
  localparam logic [TxCntW-1:0]   TxCntLast  = TxCntW'(CLOCKS_PER_PULSE - 1);

  if (WidthBusKx % BITS_PER_WORD != 0) begin : g_bad_kx_width
    $error("K/X bus width must be a multiple of BITS_PER_WORD");
  end
  if (WidthBusY % BITS_PER_WORD != 0) begin : g_bad_y_width
    $error("Y bus width must be a multiple of BITS_PER_WORD");
  end
  if (PACKET_SIZE_TX < BITS_PER_WORD + 2) begin : g_bad_packet
    $error("PACKET_SIZE_TX must be at least BITS_PER_WORD+2");
  end

  // Reset asserts asynchronously, releases two clocks after rstn rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_sync_q <= 2'b00;
    else       rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [BITS_PER_WORD-1:0] rx_word;
  logic                     rx_valid;

  uart_rx_word #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD)
  ) u_rx (
    .clk_i  (clk),
    .rst_ni (rst_int_n),
    .rx_i   (rx),
    .word_o (rx_word),
    .valid_o(rx_valid)
  );

  // The final word is the top slice, so only the lower part needs storage.
  logic [WidthBusKx-BITS_PER_WORD-1:0] kx_q, kx_d;
  logic [WidthBusKx-1:0]               frame_q, frame_d;
  logic [WordCntW-1:0]                 wcnt_q, wcnt_d;
  logic                                busy_q, busy_d;
  logic [RowW-1:0]                     row_q, row_d;
  logic [WidthBusY-1:0]                ybuf_q, ybuf_d;
  logic signed [WidthY-1:0]            row_acc;
  logic                                res_valid;

  always_comb begin
    logic signed [W_K-1:0]     k_el;
    logic signed [W_X-1:0]     x_el;
    logic signed [W_X+W_K-1:0] prod;
    row_acc = '0;
    k_el    = '0;
    x_el    = '0;
    prod    = '0;
    for (int c = 0; c < C; c++) begin
      k_el    = $signed(frame_q[C*W_X + (int'(row_q)*C + c)*W_K +: W_K]);
      x_el    = $signed(frame_q[c*W_X +: W_X]);
      prod    = (W_X+W_K)'(k_el) * (W_X+W_K)'(x_el);
      row_acc = row_acc + WidthY'(prod);
    end
  end

  always_comb begin
    kx_d      = kx_q;
    frame_d   = frame_q;
    wcnt_d    = wcnt_q;
    busy_d    = busy_q;
    row_d     = row_q;
    ybuf_d    = ybuf_q;
    res_valid = 1'b0;
    if (busy_q) begin
      ybuf_d[row_q*W_Y_OUT +: W_Y_OUT] = W_Y_OUT'(row_acc);
      if (row_q == RowLast) begin
        busy_d    = 1'b0;
        res_valid = 1'b1;
      end else begin
        row_d = row_q + RowW'(1);
      end
    end
    if (rx_valid) begin
      if (wcnt_q == WordLast) begin
        wcnt_d  = '0;
        frame_d = {rx_word, kx_q};
        busy_d  = 1'b1;
        row_d   = '0;
      end else begin
        kx_d[wcnt_q*BITS_PER_WORD +: BITS_PER_WORD] = rx_word;
        wcnt_d = wcnt_q + WordCntW'(1);
      end
    end
  end

  logic [WidthBusY-1:0]      pend_q, pend_d;
  logic                      pend_valid_q, pend_valid_d;
  tx_state_e                 tx_state_q, tx_state_d;
  logic [WidthBusY-1:0]      act_q, act_d;
  logic [TxWordW-1:0]        tword_q, tword_d;
  logic [TxBitW-1:0]         tbit_q, tbit_d;
  logic [TxCntW-1:0]         tcnt_q, tcnt_d;
  logic                      tx_q, tx_d;
  logic [PACKET_SIZE_TX-1:0] pkt;

  assign tx = tx_q;

  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    tx_state_d   = tx_state_q;
    act_d        = act_q;
    tword_d      = tword_q;
    tbit_d       = tbit_q;
    tcnt_d       = tcnt_q;
    tx_d         = 1'b1;
    pkt = {{(PACKET_SIZE_TX-BITS_PER_WORD-1){1'b1}}, act_q[BITS_PER_WORD-1:0], 1'b0};
    unique case (tx_state_q)
      TxIdle: begin
        if (pend_valid_q) begin
          act_d        = pend_q;
          pend_valid_d = 1'b0;
          tword_d      = '0;
          tbit_d       = '0;
          tcnt_d       = '0;
          tx_state_d   = TxSend;
        end
      end
      TxSend: begin
        tx_d = pkt[tbit_q];
        if (tcnt_q == TxCntLast) begin
          tcnt_d = '0;
          if (tbit_q == TxBitLast) begin
            tbit_d = '0;
            act_d  = act_q >> BITS_PER_WORD;
            if (tword_q == TxWordLast) tx_state_d = TxIdle;
            else                       tword_d    = tword_q + TxWordW'(1);
          end else begin
            tbit_d = tbit_q + TxBitW'(1);
          end
        end else begin
          tcnt_d = tcnt_q + TxCntW'(1);
        end
      end
    endcase
    // A fresh result replaces whatever is still waiting in the pending slot.
    if (res_valid) begin
      pend_d       = ybuf_d;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      kx_q         <= '0;
      frame_q      <= '0;
      wcnt_q       <= '0;
      busy_q       <= 1'b0;
      row_q        <= '0;
      ybuf_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      tx_state_q   <= TxIdle;
      act_q        <= '0;
      tword_q      <= '0;
      tbit_q       <= '0;
      tcnt_q       <= '0;
      tx_q         <= 1'b1;
    end else begin
      kx_q         <= kx_d;
      frame_q      <= frame_d;
      wcnt_q       <= wcnt_d;
      busy_q       <= busy_d;
      row_q        <= row_d;
      ybuf_q       <= ybuf_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      tx_state_q   <= tx_state_d;
      act_q        <= act_d;
      tword_q      <= tword_d;
      tbit_q       <= tbit_d;
      tcnt_q       <= tcnt_d;
      tx_q         <= tx_d;
    end
  end

endmodule

// File: tb/tb_mvm_uart_system.sv
// Bench for mvm_uart_system: drives framed bytes on rx, queues the expected
// result bytes, and a separate monitor decodes tx and compares in order.
module tb_mvm_uart_system;
  import mvm_uart_pkg::*;

  localparam int unsigned Cpp      = 4;
  localparam int unsigned NumKx    = N_WORDS_KX;
  localparam int unsigned NumStops = 13 - 8 - 1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic rx   = 1'b1;
  logic tx;

  always #5 clk = ~clk;

  mvm_uart_system #(
    .CLOCKS_PER_PULSE(Cpp)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .rx  (rx),
    .tx  (tx)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  fb[NumKx];
  logic [31:0] yv[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx = 1'b0;
    repeat (Cpp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (Cpp) @(negedge clk);
    end
    rx = 1'b1;
    repeat (Cpp + gap) @(negedge clk);
  endtask

  task automatic send_frame(input int gmin, input int gmax, input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(fb[i], int'($urandom_range(gmax, gmin)));
  endtask

  task automatic push_expect();
    logic [31:0] w;
    for (int r = 0; r < 8; r++) begin
      w = yv[r];
      for (int j = 0; j < 4; j++) exp_q.push_back(w[8*j +: 8]);
    end
  endtask

  // Reference dot products straight from the wire order: x[0..7], then k row-major.
  task automatic model();
    int s;
    for (int r = 0; r < 8; r++) begin
      s = 0;
      for (int c = 0; c < 8; c++) s = s + int'($signed(fb[8 + r*8 + c])) * int'($signed(fb[c]));
      yv[r] = s;
    end
  endtask

  task automatic fill(input logic [7:0] xv, input logic [7:0] kv, input logic [31:0] y);
    for (int i = 0; i < NumKx; i++) fb[i] = (i < 8) ? xv : kv;
    for (int r = 0; r < 8; r++) yv[r] = y;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20000 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
    repeat (100) @(negedge clk);
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic       stop_ok;
    @(posedge rstn);
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (Cpp / 2) @(negedge clk);
        check("start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (Cpp) @(negedge clk);
          b[i] = tx;
        end
        stop_ok = 1'b1;
        for (int i = 0; i < NumStops; i++) begin
          repeat (Cpp) @(negedge clk);
          if (tx !== 1'b1) stop_ok = 1'b0;
        end
        check("stop_bits", stop_ok, 1'b1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, required no output at %0t", b, $time);
        end else begin
          check("tx_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : stim
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_tx", tx, 1'b1);

    fill(8'h00, 8'h00, 32'h0000_0000);
    push_expect();
    send_frame(1, 1, NumKx);
    fill(8'h7F, 8'h7F, 32'h0001_F808);
    push_expect();
    send_frame(1, 1, NumKx);
    fill(8'h80, 8'h80, 32'h0002_0000);
    push_expect();
    send_frame(1, 1, NumKx);
    fill(8'h7F, 8'h80, 32'hFFFE_0400);
    push_expect();
    send_frame(1, 1, NumKx);

    // x = 1..8, K = identity, so y[r] = r+1 checks row/column placement.
    for (int i = 0; i < NumKx; i++) fb[i] = 8'h00;
    for (int c = 0; c < 8; c++) fb[c] = 8'(c + 1);
    for (int r = 0; r < 8; r++) begin
      fb[8 + r*8 + r] = 8'h01;
      yv[r] = 32'(r + 1);
    end
    push_expect();
    send_frame(1, 1, NumKx);

    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < NumKx; i++) fb[i] = 8'($urandom);
      model();
      push_expect();
      send_frame(1, 20, NumKx);
      repeat ($urandom_range(100, 1)) @(negedge clk);
    end
    wait_drain();

    for (int i = 0; i < NumKx; i++) fb[i] = 8'($urandom);
    send_frame(1, 3, 30);
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      check("reset_hold_tx", tx, 1'b1);
    end
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < NumKx; i++) fb[i] = 8'($urandom);
    model();
    push_expect();
    send_frame(1, 5, NumKx);
    wait_drain();
    check("after_reset_idle_tx", tx, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
